bus_fabric: RTL and testbench

BUS_FABRIC -- requirements
Module: bus_fabric

---
 rtl/bus_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/bus_fabric.sv | 138 +++++++++++++
 tb/tb_bus_fabric.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and default sizing for the register bus fabric.
package bus_pkg;

   localparam int DEF_NUM_MASTERS = 2;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_ADDR_W      = 5;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_EXEC   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_EXEC  = 2'd2
   } op_t;

   // Multiply takes priority over write; neither flag means read.
   function automatic op_t decode_op(input logic exec, input logic write);
      if (exec)
         return OP_EXEC;
      else if (write)
         return OP_WRITE;
      return OP_READ;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted master.
module rr_arbiter
   import bus_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_MASTERS-1:0] req,
   input  logic                   advance,
   output logic [NUM_MASTERS-1:0] grant
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   logic [IDX_W-1:0] r_last;
   logic [IDX_W-1:0] w_pos;
   logic [IDX_W-1:0] w_grant_idx;
   logic             w_found;
   int               w_idx;

   always_comb begin
      grant   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      w_pos   = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_idx = int'(r_last) + 1 + i;
         if (w_idx >= NUM_MASTERS)
            w_idx = w_idx - NUM_MASTERS;
         w_pos = IDX_W'(w_idx);
         if (req[w_pos] && !w_found) begin
            grant[w_pos] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

   always_comb begin
      w_grant_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (grant[i])
            w_grant_idx = IDX_W'(i);
   end

   // Reset to the highest index so master 0 is searched first.
   always_ff @(posedge clk) begin
      if (rst)
         r_last <= IDX_W'(NUM_MASTERS - 1);
      else if (advance && w_found)
         r_last <= w_grant_idx;
   end

endmodule

// File: rtl/bus_fabric.sv
// Multi-master register file with read/write and a two-operand multiply op.
//
//   state    | meaning
//   S_IDLE   | waiting for any m_valid; captures winner's request
//   S_ACCESS | register read/write, or operand fetch for exec
//   S_EXEC   | multiply and write product to target register
//   S_RESP   | one-cycle m_ready pulse to the granted master
module bus_fabric
   import bus_pkg::*;
#(
   parameter int NUM_MASTERS = DEF_NUM_MASTERS,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_MASTERS-1:0]              m_valid,
   input  logic [NUM_MASTERS-1:0]              m_write,
   input  logic [NUM_MASTERS-1:0]              m_exec,
   input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_addr,
   input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_wdata,
   output logic [NUM_MASTERS-1:0]              m_ready,
   output logic [DATA_W-1:0]                   result_data,
   output logic [NUM_MASTERS-1:0]              grant,
   output logic                                busy
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   state_t                  r_state;
   state_t                  w_next_state;
   op_t                     r_op;
   logic [ADDR_W-1:0]       r_addr;
   logic [DATA_W-1:0]       r_wdata;
   logic [DATA_W-1:0]       r_op_a;
   logic [DATA_W-1:0]       r_op_b;
   logic [DATA_W-1:0]       r_result;
   logic [DATA_W-1:0]       w_prod;
   logic [NUM_MASTERS-1:0]  r_grant;
   logic [NUM_MASTERS-1:0]  w_arb_grant;
   logic [IDX_W-1:0]        w_sel_idx;
   logic                    w_capture;
   logic [DATA_W-1:0]       r_regs [DEPTH];

   assign w_capture = (r_state == S_IDLE) && (|m_valid);
   assign w_prod    = r_op_a * r_op_b;

   rr_arbiter #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (m_valid),
      .advance (w_capture),
      .grant   (w_arb_grant)
   );

   always_comb begin
      w_sel_idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (w_arb_grant[i])
            w_sel_idx = IDX_W'(i);
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_capture) w_next_state = S_ACCESS;
         S_ACCESS: w_next_state = (r_op == OP_EXEC) ? S_EXEC : S_RESP;
         S_EXEC:   w_next_state = S_RESP;
         S_RESP:   w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = (r_state != S_IDLE);
      m_ready = (r_state == S_RESP) ? r_grant : '0;
   end

   // Operands are latched in ACCESS, so an exec whose target is also an
   // operand multiplies the pre-write value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant  <= '0;
         r_op     <= OP_READ;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_op_a   <= '0;
         r_op_b   <= '0;
         r_result <= '0;
         for (int i = 0; i < DEPTH; i++)
            r_regs[i] <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_capture) begin
                  r_grant <= w_arb_grant;
                  r_op    <= decode_op(m_exec[w_sel_idx], m_write[w_sel_idx]);
                  r_addr  <= m_addr[w_sel_idx];
                  r_wdata <= m_wdata[w_sel_idx];
               end
            end
            S_ACCESS: begin
               case (r_op)
                  OP_WRITE: begin
                     r_regs[r_addr] <= r_wdata;
                     r_result       <= r_wdata;
                  end
                  OP_EXEC: begin
                     r_op_a <= r_regs[r_wdata[ADDR_W-1:0]];
                     r_op_b <= r_regs[r_wdata[2*ADDR_W-1:ADDR_W]];
                  end
                  default: r_result <= r_regs[r_addr];
               endcase
            end
            S_EXEC: begin
               r_regs[r_addr] <= w_prod;
               r_result       <= w_prod;
            end
            S_RESP:  r_grant <= '0;
            default: r_grant <= '0;
         endcase
      end
   end

   assign result_data = r_result;
   assign grant       = r_grant;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed and randomized bench for bus_fabric against a behavioural model.
module tb_bus_fabric;
   import bus_pkg::*;

   localparam int NM    = 2;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NM-1:0]           m_valid;
   logic [NM-1:0]           m_write;
   logic [NM-1:0]           m_exec;
   logic [NM-1:0][AW-1:0]   m_addr;
   logic [NM-1:0][DW-1:0]   m_wdata;
   logic [NM-1:0]           m_ready;
   logic [DW-1:0]           result_data;
   logic [NM-1:0]           grant;
   logic                    busy;

   bus_fabric #(
      .NUM_MASTERS (NM),
      .DATA_W      (DW),
      .ADDR_W      (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .m_valid     (m_valid),
      .m_write     (m_write),
      .m_exec      (m_exec),
      .m_addr      (m_addr),
      .m_wdata     (m_wdata),
      .m_ready     (m_ready),
      .result_data (result_data),
      .grant       (grant),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model: register contents, last winner, per-master pending request
   logic [DW-1:0] mregs [DEPTH];
   int            mlast;
   bit            pend    [NM];
   int            t_op    [NM];   // 0 read, 1 write, 2 exec
   logic [AW-1:0] t_addr  [NM];
   logic [DW-1:0] t_wdata [NM];
   int            waited  [NM];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NM; i++) begin
         m_valid[i] = pend[i];
         m_write[i] = (t_op[i] == 1);
         m_exec[i]  = (t_op[i] == 2);
         m_addr[i]  = t_addr[i];
         m_wdata[i] = t_wdata[i];
      end
   endtask

   task automatic post(input int m, input int op, input int addr, input logic [DW-1:0] wd);
      pend[m]    = 1'b1;
      t_op[m]    = op;
      t_addr[m]  = AW'(addr);
      t_wdata[m] = wd;
      waited[m]  = 0;
      drive();
   endtask

   task automatic rand_txn(input int m);
      int op;
      logic [DW-1:0] wd;
      op = $urandom_range(0, 2);
      wd = $urandom();
      if (op == 2 && $urandom_range(0, 1) == 1)
         wd = {22'($urandom()), 10'($urandom())};
      else if (op == 1 && $urandom_range(0, 1) == 1)
         wd = DW'($urandom_range(0, 200));
      post(m, op, $urandom_range(0, DEPTH - 1), wd);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mregs[i] = '0;
      mlast = NM - 1;
      for (int i = 0; i < NM; i++) begin
         pend[i]   = 1'b0;
         waited[i] = 0;
         t_op[i]   = 0;
         t_addr[i] = '0;
         t_wdata[i] = '0;
      end
   endtask

   task automatic do_reset(input int cycles);
      rst = 1'b1;
      model_reset();
      drive();
      repeat (cycles) @(negedge clk);
      check("rst_grant", 64'(grant), 64'(0));
      check("rst_ready", 64'(m_ready), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_result", 64'(result_data), 64'(0));
      rst = 1'b0;
   endtask

   task automatic serve_one(input bit reissue, output int won);
      int n;
      int lat;
      int exp_lat;
      logic [DW-1:0] exp_res;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [63:0]   p;
      won = -1;
      for (int k = 1; k <= NM; k++)
         if (won < 0 && pend[(mlast + k) % NM]) won = (mlast + k) % NM;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (grant == '0 && n < 20);
      check("grant_seen", 64'(grant != '0), 64'(1));
      if (grant == '0) return;
      check("grant_winner", 64'(grant), 64'(1) << won);
      check("no_starve", 64'(waited[won] <= NM - 1), 64'(1));
      if (t_op[won] == 1) begin
         mregs[t_addr[won]] = t_wdata[won];
         exp_res = t_wdata[won];
         exp_lat = 2;
      end else if (t_op[won] == 0) begin
         exp_res = mregs[t_addr[won]];
         exp_lat = 2;
      end else begin
         a = mregs[t_wdata[won] % DEPTH];
         b = mregs[(t_wdata[won] / DEPTH) % DEPTH];
         p = 64'(a) * 64'(b);
         exp_res = p[DW-1:0];
         mregs[t_addr[won]] = exp_res;
         exp_lat = 3;
      end
      mlast = won;
      for (int i = 0; i < NM; i++)
         if (pend[i] && i != won) waited[i]++;
      lat = 1;
      do begin
         @(negedge clk);
         lat++;
      end while (m_ready == '0 && lat < 10);
      check("latency", 64'(lat), 64'(exp_lat));
      check("ready_owner", 64'(m_ready), 64'(1) << won);
      check("resp_data", 64'(result_data), 64'(exp_res));
      check("resp_busy", 64'(busy), 64'(1));
      if (reissue)
         rand_txn(won);
      else
         pend[won] = 1'b0;
      drive();
      @(negedge clk);
      check("ready_one_cycle", 64'(m_ready), 64'(0));
      check("idle_grant", 64'(grant), 64'(0));
      check("idle_busy", 64'(busy), 64'(0));
      check("data_held", 64'(result_data), 64'(exp_res));
   endtask

   initial begin
      int w;
      int n;
      rst = 1'b1;
      model_reset();
      drive();
      do_reset(3);

      // write then read
      post(0, 1, 3, 32'h0000_00AB); serve_one(0, w);
      post(0, 0, 3, 32'h0);         serve_one(0, w);
      check("wr_rd_value", 64'(result_data), 64'h0000_00AB);

      // exec 6*7 into reg16
      post(0, 1, 1, 32'd6); serve_one(0, w);
      post(1, 1, 2, 32'd7); serve_one(0, w);
      post(1, 2, 16, (32'd2 << 5) | 32'd1); serve_one(0, w);
      check("exec_42", 64'(result_data), 64'd42);
      post(0, 0, 16, 32'h0); serve_one(0, w);
      check("reg16_42", 64'(result_data), 64'd42);

      // overflow truncation
      post(0, 1, 1, 32'h0001_0000); serve_one(0, w);
      post(0, 1, 2, 32'h0001_0000); serve_one(0, w);
      post(1, 2, 5, (32'd2 << 5) | 32'd1); serve_one(0, w);
      check("exec_overflow", 64'(result_data), 64'd0);

      // exec whose target is also both operands
      post(0, 1, 4, 32'd3); serve_one(0, w);
      post(1, 2, 4, (32'd4 << 5) | 32'd4); serve_one(0, w);
      post(0, 0, 4, 32'h0); serve_one(0, w);
      check("self_operand", 64'(result_data), 64'd9);

      // reset while in EXEC aborts: reg16 holds 42 and would become 9*0xAB
      post(1, 2, 16, (32'd3 << 5) | 32'd4);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (grant == '0 && n < 20);
      check("abort_grant", 64'(grant), 64'b10);
      @(negedge clk);
      check("abort_exec_noready", 64'(m_ready), 64'(0));
      check("abort_exec_busy", 64'(busy), 64'(1));
      rst = 1'b1;
      @(negedge clk);
      check("abort_ready", 64'(m_ready), 64'(0));
      check("abort_grant_clr", 64'(grant), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      model_reset();
      drive();
      @(negedge clk);
      check("abort_ready2", 64'(m_ready), 64'(0));
      rst = 1'b0;
      post(0, 0, 16, 32'h0); serve_one(0, w);
      check("abort_target_zero", 64'(result_data), 64'd0);

      // both masters requesting continuously after reset
      do_reset(2);
      rand_txn(0);
      rand_txn(1);
      for (int i = 0; i < 4; i++) begin
         serve_one(1, w);
         check("alternate", 64'(w), 64'(i % 2));
      end
      for (int i = 0; i < NM; i++) pend[i] = 1'b0;
      drive();

      // randomized traffic
      for (int it = 0; it < 60; it++) begin
         bit any;
         any = 1'b0;
         for (int m = 0; m < NM; m++) begin
            if (!pend[m] && $urandom_range(0, 1) == 1) rand_txn(m);
            if (pend[m]) any = 1'b1;
         end
         if (!any) rand_txn($urandom_range(0, NM - 1));
         serve_one(0, w);
      end
      for (int i = 0; i < NM; i++) pend[i] = 1'b0;
      drive();

      // read back every register against the model
      for (int r = 0; r < DEPTH; r++) begin
         post(r % NM, 0, r, 32'h0);
         serve_one(0, w);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
